// File: rtl/rom_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch path: field bounds, opcode values,
// delay operand width and fetch FSM state encodings.
package rom_fetch_sequencer_pkg;

  localparam int unsigned AddrWidth   = 16;
  localparam int unsigned InstrWidth  = 28;
  localparam int unsigned OpcodeMsb   = 27;
  localparam int unsigned OpcodeLsb   = 24;
  localparam int unsigned OpcodeWidth = OpcodeMsb - OpcodeLsb + 1;
  localparam int unsigned DelayWidth  = 24;

  // Opcode values of the mini-ALU; only OpNop has meaning to the fetch stage.
  localparam logic [OpcodeWidth-1:0] OpNop = 4'h0;
  localparam logic [OpcodeWidth-1:0] OpAdd = 4'h1;
  localparam logic [OpcodeWidth-1:0] OpSub = 4'h2;
  localparam logic [OpcodeWidth-1:0] OpLod = 4'h3;
  localparam logic [OpcodeWidth-1:0] OpSto = 4'h4;
  localparam logic [OpcodeWidth-1:0] OpBra = 4'h5;
  localparam logic [OpcodeWidth-1:0] OpJmp = 4'h6;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StIssue = 2'd1,
    StDelay = 2'd2,
    StHalt  = 2'd3
  } fetch_state_e;

  function automatic logic [OpcodeWidth-1:0] get_opcode(input logic [InstrWidth-1:0] instr);
    return instr[OpcodeMsb:OpcodeLsb];
  endfunction

endpackage

// File: rtl/rom_fetch_sequencer_if.sv
// Fetch-stage bus: ROM port, decode handshake, redirect and halt controls.
// FETCH_SINGLE_STEP_EN adds the iStep input.
interface rom_fetch_sequencer_if;
  import rom_fetch_sequencer_pkg::*;

  logic [AddrWidth-1:0]  oRomAddress;
  logic [InstrWidth-1:0] iRomInstruction;
  logic [InstrWidth-1:0] oInstruction;
  logic [AddrWidth-1:0]  oPC;
  logic                  oValid;
  logic                  iReady;
  logic                  iBranchTaken;
  logic [AddrWidth-1:0]  iBranchTarget;
  logic                  iHalt;
  logic                  oDelayActive;
`ifdef FETCH_SINGLE_STEP_EN
  logic                  iStep;
`endif

  // The fetch sequencer side.
  modport master (
    output oRomAddress,
    input  iRomInstruction,
    output oInstruction,
    output oPC,
    output oValid,
    input  iReady,
    input  iBranchTaken,
    input  iBranchTarget,
    input  iHalt,
`ifdef FETCH_SINGLE_STEP_EN
    input  iStep,
`endif
    output oDelayActive
  );

  // The ROM / decode / execute side.
  modport slave (
    input  oRomAddress,
    output iRomInstruction,
    input  oInstruction,
    input  oPC,
    input  oValid,
    output iReady,
    output iBranchTaken,
    output iBranchTarget,
    output iHalt,
`ifdef FETCH_SINGLE_STEP_EN
    output iStep,
`endif
    input  oDelayActive
  );

endinterface

// File: rtl/rom_fetch_sequencer_fetch_delay_counter.sv
// 24-bit loadable down-counter used to time NOP delays. Clear beats load beats decrement.
module fetch_delay_counter
  import rom_fetch_sequencer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [DelayWidth-1:0] load_value_i,
  input  logic                  dec_i,
  output logic                  zero_o
);

  localparam logic [DelayWidth-1:0] One = 1;

  logic [DelayWidth-1:0] count_q, count_d;

  // Next count: synchronous clear, load, or single-step decrement.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i) begin
      count_d = count_q - One;
    end
  end

  // Count register, cleared asynchronously with the parent.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Instruction fetch controller: owns the PC, fetches from ROM, hands instructions to
// decode over valid/ready, absorbs NOP delays locally and takes execute-stage redirects.
// Optional macro FETCH_SINGLE_STEP_EN gates each fetch on an iStep pulse.
module rom_fetch_sequencer
  import rom_fetch_sequencer_pkg::*;
(
  input logic                   Clock,
  input logic                   Reset,
  rom_fetch_sequencer_if.master bus
);

  localparam logic [AddrWidth-1:0] PcInc = 1;

  fetch_state_e          state_q, state_d;
  logic [AddrWidth-1:0]  pc_q, pc_d;
  logic [InstrWidth-1:0] instr_q, instr_d;
  logic [AddrWidth-1:0]  opc_q, opc_d;
  logic                  valid_q, valid_d;
  logic                  delay_active_q, delay_active_d;

  logic cnt_clear, cnt_load, cnt_dec, cnt_zero;
  logic step_ok;
  logic is_nop;

`ifdef FETCH_SINGLE_STEP_EN
  assign step_ok = bus.iStep;
`else
  assign step_ok = 1'b1;
`endif

  assign is_nop = (get_opcode(bus.iRomInstruction) == OpNop);

  fetch_delay_counter u_delay (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .clear_i      (cnt_clear),
    .load_i       (cnt_load),
    .load_value_i (bus.iRomInstruction[DelayWidth-1:0]),
    .dec_i        (cnt_dec),
    .zero_o       (cnt_zero)
  );

  // Next-state and datapath updates; a redirect overrides everything else.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    opc_d     = opc_q;
    valid_d   = valid_q;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;

    case (state_q)
      StFetch: begin
        if (step_ok) begin
          if (bus.iHalt) begin
            state_d = StHalt;
          end else if (is_nop) begin
            cnt_load = 1'b1;
            state_d  = StDelay;
          end else begin
            instr_d = bus.iRomInstruction;
            opc_d   = pc_q;
            valid_d = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (bus.iReady) begin
          valid_d = 1'b0;
          pc_d    = pc_q + PcInc;
          state_d = StFetch;
        end
      end
      StDelay: begin
        // Operand N spends N+1 cycles here: exit happens on the cycle the count reads 0.
        if (cnt_zero) begin
          pc_d    = pc_q + PcInc;
          state_d = StFetch;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StHalt: begin
        if (!bus.iHalt) begin
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    if (bus.iBranchTaken) begin
      pc_d      = bus.iBranchTarget;
      valid_d   = 1'b0;
      cnt_clear = 1'b1;
      state_d   = StFetch;
    end
  end

  assign delay_active_d = (state_d == StDelay);

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q        <= StFetch;
      pc_q           <= '0;
      instr_q        <= '0;
      opc_q          <= '0;
      valid_q        <= 1'b0;
      delay_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      opc_q          <= opc_d;
      valid_q        <= valid_d;
      delay_active_q <= delay_active_d;
    end
  end

  assign bus.oRomAddress  = pc_q;
  assign bus.oInstruction = instr_q;
  assign bus.oPC          = opc_q;
  assign bus.oValid       = valid_q;
  assign bus.oDelayActive = delay_active_q;

endmodule

// File: doc/rom_fetch_sequencer.md
# rom_fetch_sequencer

Instruction fetch controller for the mini-ALU processor. It owns the program counter, drives the instruction ROM address, and registers each fetched 28-bit instruction into a valid/ready handshake toward decode. It consumes delay-`NOP`s locally by stalling for the operand count, and it accepts branch/jump redirects from the execute stage.

## Interface
Parameters:
- None. Widths are fixed by the shared definitions: 16-bit address, 28-bit instruction, 4-bit opcode in bits [27:24], 24-bit `NOP` delay operand in bits [23:0].

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- oRomAddress  out  16  ROM address; equals the PC register (no combinational path from inputs)
- iRomInstruction  in  28  ROM data; combinational in oRomAddress
- oInstruction  out  28  registered instruction presented to decode
- oPC  out  16  address the current oInstruction was fetched from
- oValid  out  1  oInstruction is valid
- iReady  in  1  decode accepts; the transfer happens when oValid & iReady are both high at a rising edge
- iBranchTaken  in  1  single-cycle redirect request from execute
- iBranchTarget  in  16  redirect address (8-bit ROM target field, zero-extended by execute)
- iHalt  in  1  level; suppresses new fetches
- oDelayActive  out  1  high while a `NOP` delay is in progress

## Operation
- States: FETCH, ISSUE, DELAY, HALT. Encodings come from the shared definitions.
- FETCH:
  - If iHalt is high, go to HALT.
  - Else, if the opcode of iRomInstruction is `NOP`: load the delay counter with bits [23:0] and go to DELAY.
  - Otherwise: latch the instruction into oInstruction, latch the PC into oPC, set oValid, and go to ISSUE.
- ISSUE:
  - Hold oInstruction stable while oValid is high and iReady is low.
  - On transfer: clear oValid, PC <= PC+1, go to FETCH.
- DELAY:
  - The counter decrements once per cycle.
  - When the counter equals 0: PC <= PC+1, go to FETCH.
  - A `NOP` with operand N therefore stalls N+1 cycles in DELAY. Operand 0 stalls 1 cycle.
- HALT:
  - Stay while iHalt is high. Return to FETCH when iHalt is low.
  - The PC is unchanged across HALT.
- Redirect: iBranchTaken has the highest priority, in every state.
  - Next state: PC <= iBranchTarget, oValid <= 0, delay counter <= 0, state <= FETCH.
  - This applies even if a transfer or a delay expiry happens in the same cycle; the redirect wins and PC+1 is discarded.
- PC arithmetic is 16-bit unsigned and wraps 0xFFFF -> 0x0000.
- Opcodes other than `NOP` are opaque to this block.
- iHalt asserted during ISSUE or DELAY takes effect only at the next FETCH.
- Reset mid-operation aborts any pending issue or delay. There is no partial transfer.

## Timing
- Reset values: oRomAddress=0, oPC=0, oInstruction=0, oValid=0, oDelayActive=0, state=FETCH, delay counter=0.
- First rising edge after Reset deasserts: ROM[0] is captured and oValid goes high.
- Non-`NOP` throughput: one instruction per 2 cycles with iReady held high (FETCH, then ISSUE).
- Redirect latency: assert iBranchTaken at edge k. oRomAddress = target after edge k. The target instruction is valid after edge k+1.
- oDelayActive is registered; it is high exactly during DELAY cycles.

## Configuration
- `FETCH_SINGLE_STEP_EN` defined:
  - Adds input iStep (1 bit).
  - FETCH advances only in a cycle where iStep is high; otherwise the block stays in FETCH with oValid=0.
  - Each iStep pulse fetches exactly one instruction. A `NOP` counts as one step, including its full delay.
  - Redirect still acts without iStep.
- Not defined: no iStep port; FETCH always advances.

## Structure
- Shared definitions file (extend the existing opcode macro file):
  - opcode field bounds
  - `NOP` opcode value (already defined there)
  - delay operand width
  - state encodings
- One sub-module: `fetch_delay_counter`, a 24-bit loadable down-counter with a zero flag and a synchronous clear. Reset is asynchronous, shared with the parent.

## Test plan
- Reset, ROM[0]=ADD, ROM[1]=STO, iReady=1 -> oValid first high after edge 1 with oPC=0. oPC=1 two cycles later. oRomAddress wraps to 0 after 0xFFFF.
- ROM[0]=`NOP` operand 3, ROM[1]=ADD -> oDelayActive high for exactly 4 cycles, oValid=0 throughout, then ADD issued with oPC=1.
- ADD at PC=5 presented, iReady low for 3 cycles -> oInstruction and oPC=5 held stable, PC not advanced. Transfer on the 4th cycle moves PC to 6.
- iBranchTaken with target 8 asserted in the same cycle as a transfer at PC=9 -> next oRomAddress=8, not 10. The instruction from 8 is valid one cycle later.
- iBranchTaken with target 2 during a `NOP` 4000 delay -> delay aborted, oDelayActive=0 next cycle, fetch from 2.
- iHalt high in FETCH at PC=3 for 10 cycles -> no oValid and PC stays 3; release resumes at 3. With `FETCH_SINGLE_STEP_EN`: two iStep pulses -> exactly two instructions issued.
